// File: rtl/stream_packer.sv
// -----------------------------------------------------------------------------
// stream_packer
//   Packs variable-length compressed records (HDR_BITS header + 8*len payload
//   bits) into fixed OUT_WIDTH-bit words, LSB-first. Both sides use
//   valid/ready handshakes. A flush request drains all full words and then
//   emits a zero-padded tail word marked with out_last. After that, flush_done
//   pulses for one cycle.
//
// Ports
//   clk        : clock, rising edge
//   reset      : asynchronous reset, active low
//   in_valid   : record present on in_data / in_len
//   in_ready   : record and/or flush accepted when asserted with its valid
//   in_data    : record bits, LSB-aligned; bits above the record are ignored
//   in_len     : payload byte count
//   flush      : request tail emission
//   out_valid  : out_data holds a word
//   out_ready  : word consumed when asserted with out_valid
//   out_data   : packed word, first-accepted bit at bit 0
//   out_last   : word is the flush tail
//   out_bits   : number of valid bits in out_data
//   flush_done : one-cycle pulse when a flush has completed
//   err_len    : sticky oversize-record flag (only with the macro below)
//
// Configuration
//   STREAM_PACKER_LEN_CHECK_EN : when defined, a record wider than IN_WIDTH
//   completes its handshake but is dropped, and err_len is set until reset.
// -----------------------------------------------------------------------------
module stream_packer #(
    parameter int IN_WIDTH  = 272,
    parameter int LEN_WIDTH = 8,
    parameter int HDR_BITS  = 16,
    parameter int OUT_WIDTH = 256
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [IN_WIDTH-1:0]        in_data,
    input  logic [LEN_WIDTH-1:0]       in_len,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OUT_WIDTH-1:0]       out_data,
    output logic                       out_last,
    output logic [$clog2(OUT_WIDTH):0] out_bits,
    output logic                       flush_done
`ifdef STREAM_PACKER_LEN_CHECK_EN
    ,
    output logic                       err_len
`endif
);

    localparam int ACC_W   = OUT_WIDTH + IN_WIDTH;
    // Largest record the len field can describe. The fill arithmetic is sized
    // for it, so an oversize length never wraps into a legal-looking value.
    localparam int REC_MAX = HDR_BITS + 8 * ((1 << LEN_WIDTH) - 1);
    localparam int FILL_W  = $clog2(((ACC_W > REC_MAX) ? ACC_W : REC_MAX) + 1);
    localparam int BITS_W  = $clog2(OUT_WIDTH) + 1;

    localparam logic [FILL_W-1:0] OUT_FILL = FILL_W'(OUT_WIDTH);
    localparam logic [BITS_W-1:0] OUT_BITS = BITS_W'(OUT_WIDTH);

    typedef enum logic [1:0] {RUN, DRAIN, TAIL} state_t;

    state_t              state, stateNext;
    logic [ACC_W-1:0]    acc, accNext;
    logic [FILL_W-1:0]   fill, fillNext;
    logic [FILL_W-1:0]   recBits;
    logic [IN_WIDTH-1:0] recMask;
    logic                accept, flushAccept, emit, recOk, flushDoneNext;

    assign recBits     = FILL_W'(HDR_BITS) + (FILL_W'(in_len) << 3);
    // Shifting by the full width or more yields zero, so the mask saturates to all ones.
    assign recMask     = ~({IN_WIDTH{1'b1}} << recBits);
    assign accept      = in_valid & in_ready;
    assign flushAccept = flush & in_ready;
    assign emit        = out_valid & out_ready;

`ifdef STREAM_PACKER_LEN_CHECK_EN
    assign recOk = (recBits <= FILL_W'(IN_WIDTH));
`else
    assign recOk = 1'b1;
`endif

    // Accept and emit are mutually exclusive: in_ready needs fill < OUT_WIDTH in
    // RUN, while out_valid needs fill >= OUT_WIDTH or the TAIL state.
    always_comb begin
        accNext       = acc;
        fillNext      = fill;
        stateNext     = state;
        flushDoneNext = 1'b0;

        if (emit) begin
            if (state == TAIL) begin
                accNext       = '0;
                fillNext      = '0;
                stateNext     = RUN;
                flushDoneNext = 1'b1;
            end else begin
                accNext  = acc >> OUT_WIDTH;
                fillNext = fill - OUT_FILL;
            end
        end

        if (accept && recOk) begin
            // Bits of acc at and above fill are always zero, so OR-ing in places the record.
            accNext  = acc | (ACC_W'(in_data & recMask) << fill);
            fillNext = fill + recBits;
        end

        // A same-cycle record is already folded into fillNext before the flush is taken.
        if (flushAccept) begin
            stateNext = DRAIN;
        end

        // DRAIN is kept only while full words remain. After that the flush
        // resolves straight to a tail word, or to completion if nothing is left.
        if (stateNext == DRAIN && fillNext < OUT_FILL) begin
            if (fillNext != '0) begin
                stateNext = TAIL;
            end else begin
                stateNext     = RUN;
                flushDoneNext = 1'b1;
            end
        end
    end

    // Register stage: state, accumulator and every output update together,
    // so outputs stay frozen while a word is stalled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= RUN;
            acc        <= '0;
            fill       <= '0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_bits   <= '0;
            out_data   <= '0;
            flush_done <= 1'b0;
        end else begin
            state      <= stateNext;
            acc        <= accNext;
            fill       <= fillNext;
            in_ready   <= (stateNext == RUN) && (fillNext < OUT_FILL);
            out_valid  <= (stateNext == TAIL) || (fillNext >= OUT_FILL);
            out_last   <= (stateNext == TAIL);
            out_bits   <= (stateNext == TAIL) ? BITS_W'(fillNext)
                        : (fillNext >= OUT_FILL) ? OUT_BITS : '0;
            out_data   <= accNext[OUT_WIDTH-1:0];
            flush_done <= flushDoneNext;
        end
    end

`ifdef STREAM_PACKER_LEN_CHECK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_len <= 1'b0;
        end else if (accept && !recOk) begin
            err_len <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_stream_packer.sv
module tb_stream_packer;

    localparam int IW = 272;
    localparam int LW = 8;
    localparam int OW = 256;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] in_data;
    logic [LW-1:0] in_len;
    logic          flush;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [OW-1:0] out_data;
    logic          out_last;
    logic [8:0]    out_bits;
    logic          flush_done;
`ifdef STREAM_PACKER_LEN_CHECK_EN
    logic          err_len;
`endif

    always #5 clk = ~clk;

    stream_packer #(.IN_WIDTH(IW), .LEN_WIDTH(LW), .HDR_BITS(16), .OUT_WIDTH(OW)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_len     (in_len),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_bits   (out_bits),
        .flush_done (flush_done)
`ifdef STREAM_PACKER_LEN_CHECK_EN
        ,
        .err_len    (err_len)
`endif
    );

    typedef struct {
        logic [OW-1:0] d;
        logic          last;
        int            bits;
    } exp_t;

    int   compared   = 0;
    int   mismatched = 0;
    exp_t expQ[$];
    bit   bq[$];        // reference model: pending bit stream, oldest bit first
    int   expDone    = 0;
    int   gotDone    = 0;
    int   readyMode  = 1; // 0 random, 1 always ready, 2 never ready
    exp_t monE;

    task automatic check(string name, logic [IW-1:0] got, logic [IW-1:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s: got %0h required %0h", name, got, want);
        end
    endtask

    function automatic logic [IW-1:0] randData();
        logic [287:0] t;
        for (int k = 0; k < 9; k++) t[k*32 +: 32] = $urandom;
        return t[IW-1:0];
    endfunction

    // Reference model: the record's bits join one long stream, and every
    // OW bits of that stream make one expected word.
    task automatic modelAccept(int len, logic [IW-1:0] d);
        int   rb;
        exp_t e;
        rb = 16 + 8 * len;
        if (rb <= IW) begin
            for (int i = 0; i < rb; i++) bq.push_back(d[i]);
        end
        while (bq.size() >= OW) begin
            e.d = '0;
            for (int i = 0; i < OW; i++) e.d[i] = bq.pop_front();
            e.last = 1'b0;
            e.bits = OW;
            expQ.push_back(e);
        end
    endtask

    task automatic modelFlush();
        exp_t e;
        if (bq.size() > 0) begin
            e.d    = '0;
            e.bits = bq.size();
            for (int i = 0; i < e.bits; i++) e.d[i] = bq.pop_front();
            e.last = 1'b1;
            expQ.push_back(e);
        end
        expDone++;
    endtask

    always @(posedge clk) begin
        #1;
        if (readyMode == 1)      out_ready = 1'b1;
        else if (readyMode == 2) out_ready = 1'b0;
        else                     out_ready = ($urandom_range(3) != 0);
    end

    // Monitor: each output handshake is compared against the scoreboard.
    always @(negedge clk) begin
        if (reset === 1'b1 && out_valid && out_ready) begin
            if (expQ.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_word: got word with out_bits %0d required no word", out_bits);
            end else begin
                monE = expQ.pop_front();
                check("out_data", out_data, monE.d);
                check("out_bits", out_bits, monE.bits);
                check("out_last", out_last, monE.last);
            end
        end
        if (reset === 1'b1 && flush_done) gotDone++;
    end

    // Present a record/flush and hold it until in_ready; return at the negedge before the accepting edge.
    task automatic drive(logic v, int len, logic [IW-1:0] d, logic fl);
        int t;
        @(posedge clk); #1;
        in_valid = v;
        in_len   = LW'(len);
        in_data  = d;
        flush    = fl;
        t = 0;
        while (1) begin
            @(negedge clk);
            if (in_ready) break;
            t++;
            if (t >= 500) begin
                compared++;
                mismatched++;
                $display("FAIL accept_timeout: in_ready %0b required 1", in_ready);
                break;
            end
        end
        if (in_ready) begin
            if (v)  modelAccept(len, d);
            if (fl) modelFlush();
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic waitIdle(int maxc);
        int t;
        t = 0;
        while ((expQ.size() != 0 || out_valid) && t < maxc) begin
            @(negedge clk);
            t++;
        end
        check("drain_in_time", (t < maxc), 1);
    endtask

    logic [IW-1:0] a, b, c;
    int            seen;

    initial begin
        reset    = 1'b0;
        in_valid = 1'b0;
        flush    = 1'b0;
        in_data  = '0;
        in_len   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready",   in_ready,   1);
        check("rst_out_valid",  out_valid,  0);
        check("rst_out_bits",   out_bits,   0);
        check("rst_flush_done", flush_done, 0);
        check("rst_out_last",   out_last,   0);
        check("rst_out_data",   out_data,   0);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);

        // Two 128-bit records form exactly one word.
        a = randData(); b = randData();
        drive(1, 14, a, 0);
        drive(1, 14, b, 0);
        idle();
        @(negedge clk);
        check("t2_valid", out_valid, 1);
        check("t2_word",  out_data, {b[127:0], a[127:0]});
        @(negedge clk);
        check("t2_empty_valid", out_valid, 0);
        check("t2_in_ready",    in_ready,  1);

        // A 256-bit record from empty becomes a word immediately.
        c = randData();
        drive(1, 30, c, 0);
        idle();
        @(negedge clk);
        check("t3_valid", out_valid, 1);
        check("t3_word",  out_data, {16'b0, c[255:0]});
        check("t3_bits",  out_bits, 256);
        @(negedge clk);
        check("t3_in_ready", in_ready, 1);

        // 240 + 272 = 512 bits -> two back-to-back words.
        drive(1, 28, randData(), 0);
        drive(1, 32, randData(), 0);
        idle();
        @(negedge clk);
        check("t4_first_valid",  out_valid, 1);
        check("t4_in_ready_low", in_ready,  0);
        @(negedge clk);
        check("t4_second_valid", out_valid, 1);
        @(negedge clk);
        check("t4_drained",  out_valid, 0);
        check("t4_in_ready", in_ready,  1);

        // Back-pressure: the word must hold still.
        readyMode = 2;
        drive(1, 14, randData(), 0);
        drive(1, 14, randData(), 0);
        idle();
        @(negedge clk);
        a = IW'(out_data);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t5_valid_hold", out_valid, 1);
            check("t5_data_hold",  out_data,  a);
            check("t5_in_ready",   in_ready,  0);
        end
        readyMode = 1;
        waitIdle(20);

        // 40-bit remainder flushed as a tail word.
        a = randData();
        drive(1, 3, a, 1);
        idle();
        @(negedge clk);
        check("t6_valid", out_valid, 1);
        check("t6_last",  out_last,  1);
        check("t6_bits",  out_bits,  40);
        check("t6_data",  out_data,  {232'b0, a[39:0]});
        seen = 0;
        for (int i = 0; i < 5 && seen == 0; i++) begin
            @(negedge clk);
            if (flush_done) seen = 1;
        end
        check("t6_flush_done_seen", seen, 1);
        @(negedge clk);
        check("t6_flush_done_pulse", flush_done, 0);

        // Flush with nothing buffered.
        drive(0, 0, '0, 1);
        idle();
        @(negedge clk);
        check("t6z_flush_done", flush_done, 1);
        check("t6z_no_word",    out_valid,  0);
        @(negedge clk);
        check("t6z_flush_done_pulse", flush_done, 0);

`ifdef STREAM_PACKER_LEN_CHECK_EN
        check("t7_err_clear", err_len, 0);
        drive(1, 33, randData(), 0);
        idle();
        @(negedge clk);
        check("t7_err_set",   err_len,   1);
        check("t7_no_word",   out_valid, 0);
        check("t7_in_ready",  in_ready,  1);
        drive(1, 30, randData(), 0);
        idle();
        waitIdle(20);
        check("t7_err_sticky", err_len, 1);
`endif

        // Reset mid-operation discards buffered bits.
        drive(1, 3, randData(), 0);
        idle();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_in_ready",  in_ready,  1);
        check("midrst_out_valid", out_valid, 0);
        reset = 1'b1;
        bq.delete();
        drive(1, 30, randData(), 0);
        idle();
        waitIdle(20);

        // Randomized traffic with random back-pressure and flushes.
        readyMode = 0;
        for (int n = 0; n < 300; n++) begin
            drive(($urandom_range(9) != 0), $urandom_range(32), randData(),
                  ($urandom_range(15) == 0));
            if ($urandom_range(3) == 0) idle();
        end
        drive(0, 0, '0, 1);
        idle();
        readyMode = 1;
        waitIdle(3000);
        repeat (3) @(negedge clk);
        check("scoreboard_empty", expQ.size(), 0);
        check("flush_done_count", gotDone, expDone);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
